// File: rtl/pipe_register.sv
// pipe_register
// Pipeline register with valid/ready handshake, a one-entry skid buffer and a
// synchronous flush. It is intended to sit between processor pipeline stages.
// Every output is registered. out_ready and in_valid only feed next-state logic,
// so a stall never creates a combinational ready path through the stage.
//
// Parameters:
//   WIDTH      payload width in bits (>= 1)
//   RESET_VAL  value loaded into main/skid on reset and on flush
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous squash of held and incoming words
//   in_valid   upstream word present on in_data
//   in_data    upstream payload
//   in_ready   stage can take a word this cycle (registered)
//   out_valid  out_data carries a valid word (registered)
//   out_data   downstream payload, driven by the main register
//   out_ready  downstream takes out_data this cycle
//   occupancy  words held, 0..2
//
// state | meaning
// EMPTY | nothing held, out_data keeps its last (meaningless) value
// BUSY  | main register valid, skid empty
// FULL  | main and skid valid, input stalled

module pipe_register #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    // The encoding equals the word count, so occupancy is simply the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain can happen.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides everything. A word delivered on this edge is still
        // consumed downstream, and a word offered upstream is dropped.
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end
    end

    // The handshake flags come from the next state. That keeps them registered
    // and still lets them line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_register.sv
module tb_pipe_register;

    logic        clk = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // 8-bit instance, RESET_VAL = 8'hA5
    logic        rst_a = 1'b0, flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [7:0]  in_data_a = 8'h00;
    logic        in_ready_a, out_valid_a;
    logic [7:0]  out_data_a;
    logic [1:0]  occ_a;

    // 32-bit instance, default RESET_VAL = 0
    logic        rst_b = 1'b0, flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [31:0] in_data_b = 32'h0;
    logic        in_ready_b, out_valid_b;
    logic [31:0] out_data_b;
    logic [1:0]  occ_b;

    pipe_register #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_a (
        .clk(clk), .rst(rst_a), .flush(flush_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
        .occupancy(occ_a)
    );

    pipe_register #(.WIDTH(32)) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
        .occupancy(occ_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ov, input logic ir,
                         input logic [1:0] oc, input logic [7:0] od);
        chk({tag, ".out_valid"}, {31'b0, out_valid_a}, {31'b0, ov});
        chk({tag, ".in_ready"},  {31'b0, in_ready_a},  {31'b0, ir});
        chk({tag, ".occupancy"}, {30'b0, occ_a},       {30'b0, oc});
        chk({tag, ".out_data"},  {24'b0, out_data_a},  {24'b0, od});
    endtask

    task automatic chk_b(input string tag, input logic ov, input logic ir,
                         input logic [1:0] oc, input logic [31:0] od);
        chk({tag, ".out_valid"}, {31'b0, out_valid_b}, {31'b0, ov});
        chk({tag, ".in_ready"},  {31'b0, in_ready_b},  {31'b0, ir});
        chk({tag, ".occupancy"}, {30'b0, occ_b},       {30'b0, oc});
        chk({tag, ".out_data"},  out_data_b,           od);
    endtask

    initial begin
        // Reset is asserted off-edge and checked before the first clock edge.
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        chk_a("reset_async", 1'b0, 1'b1, 2'd0, 8'hA5);
        chk_b("reset_async_b", 1'b0, 1'b1, 2'd0, 32'h0);
        #14;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Streaming with out_ready held high.
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; in_data_a = 8'h01; tick();
        chk_a("stream_01", 1'b1, 1'b1, 2'd1, 8'h01);
        in_data_a = 8'h02; tick();
        chk_a("stream_02", 1'b1, 1'b1, 2'd1, 8'h02);
        in_data_a = 8'h03; tick();
        chk_a("stream_03", 1'b1, 1'b1, 2'd1, 8'h03);
        in_valid_a = 1'b0; tick();
        chk_a("stream_drain", 1'b0, 1'b1, 2'd0, 8'h03);

        // Backpressure: 10 lands in main, 11 in skid, 12 is held off.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_data_a = 8'h10; tick();
        chk_a("bp_10", 1'b1, 1'b1, 2'd1, 8'h10);
        in_data_a = 8'h11; tick();
        chk_a("bp_full", 1'b1, 1'b0, 2'd2, 8'h10);
        in_data_a = 8'h12; tick();
        chk_a("bp_hold", 1'b1, 1'b0, 2'd2, 8'h10);
        out_ready_a = 1'b1; tick();
        chk_a("bp_out_11", 1'b1, 1'b1, 2'd1, 8'h11);
        tick();
        chk_a("bp_out_12", 1'b1, 1'b1, 2'd1, 8'h12);
        in_valid_a = 1'b0; tick();
        chk_a("bp_drain", 1'b0, 1'b1, 2'd0, 8'h12);

        // Simultaneous in and out while BUSY.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_data_a = 8'h20; tick();
        chk_a("sim_20", 1'b1, 1'b1, 2'd1, 8'h20);
        in_data_a = 8'h21; out_ready_a = 1'b1; tick();
        chk_a("sim_21", 1'b1, 1'b1, 2'd1, 8'h21);
        in_valid_a = 1'b0; tick();
        chk_a("sim_drain", 1'b0, 1'b1, 2'd0, 8'h21);

        // Flush from FULL with a word offered on the same edge.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_data_a = 8'h30; tick();
        in_data_a = 8'h31; tick();
        chk_a("fl_full", 1'b1, 1'b0, 2'd2, 8'h30);
        in_data_a = 8'h32; flush_a = 1'b1; tick();
        chk_a("fl_after", 1'b0, 1'b1, 2'd0, 8'hA5);
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1; tick();
        chk_a("fl_no_32", 1'b0, 1'b1, 2'd0, 8'hA5);
        tick();
        chk_a("fl_idle", 1'b0, 1'b1, 2'd0, 8'hA5);

        // 32-bit instance: fill, reset mid-run, then restart.
        out_ready_b = 1'b0;
        in_valid_b = 1'b1; in_data_b = 32'hDEADBEEF; tick();
        chk_b("w32_first", 1'b1, 1'b1, 2'd1, 32'hDEADBEEF);
        in_data_b = 32'hCAFEF00D; tick();
        chk_b("w32_full", 1'b1, 1'b0, 2'd2, 32'hDEADBEEF);
        in_valid_b = 1'b0;
        #2;
        rst_b = 1'b1;
        #1;
        chk_b("w32_rst_async", 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        rst_b = 1'b0;
        chk_b("w32_rst_held", 1'b0, 1'b1, 2'd0, 32'h0);
        out_ready_b = 1'b1;
        in_valid_b = 1'b1; in_data_b = 32'h00000001; tick();
        chk_b("w32_restart", 1'b1, 1'b1, 2'd1, 32'h00000001);
        in_valid_b = 1'b0; tick();
        chk_b("w32_drain", 1'b0, 1'b1, 2'd0, 32'h00000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
